// File: rtl/cpu_run_control.sv
// Run/stop controller for the pipelined CPU: run, pause, single-step, PC breakpoint,
// halt on the write-back HALT opcode, and saturating cycle/retired counters.
module cpu_run_control #(
    parameter int                      IR_WIDTH  = 16,
    parameter int                      OP_MSB    = 15,
    parameter int                      OP_LSB    = 11,
    parameter logic [OP_MSB-OP_LSB:0]  HALT_OP   = 5'b00001,
    parameter int                      PC_WIDTH  = 8,
    parameter int                      CNT_WIDTH = 16
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic                 enable_i,
    input  logic                 step_mode_i,
    input  logic                 step_req_i,
    input  logic                 bp_en_i,
    input  logic [PC_WIDTH-1:0]  bp_addr_i,
    input  logic [PC_WIDTH-1:0]  pc_i,
    input  logic [IR_WIDTH-1:0]  wb_ir_i,
    input  logic                 wb_valid_i,
    output logic                 run_o,
    output logic [2:0]           state_o,
    output logic                 halted_o,
    output logic                 bp_hit_o,
    output logic [CNT_WIDTH-1:0] cycle_count_o,
    output logic [CNT_WIDTH-1:0] retired_count_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EXEC   = 3'd1,
        ST_PAUSE  = 3'd2,
        ST_STEP   = 3'd3,
        ST_HALTED = 3'd4
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_e               state_q, state_d;
    logic                 run_q, halted_q, bp_hit_q, bp_hit_d;
    logic                 step_req_q, bp_armed_q, bp_armed_d;
    logic                 clr_cnt_s;
    logic [CNT_WIDTH-1:0] cycle_count_q, cycle_count_d;
    logic [CNT_WIDTH-1:0] retired_count_q, retired_count_d;
    logic                 halt_det_s, step_pulse_s, bp_match_s;
    logic                 unused_ir_s;

    assign halt_det_s   = wb_valid_i & (wb_ir_i[OP_MSB:OP_LSB] == HALT_OP);
    assign step_pulse_s = step_req_i & ~step_req_q;
    assign bp_match_s   = bp_en_i & bp_armed_q & (pc_i == bp_addr_i);
    assign unused_ir_s  = ^wb_ir_i;

    // Next-state, breakpoint arming and counter-clear decode
    always_comb begin
        state_d    = state_q;
        bp_hit_d   = 1'b0;
        bp_armed_d = bp_armed_q;
        clr_cnt_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i && enable_i) begin
                    clr_cnt_s = 1'b1;
                    if (step_mode_i) begin
                        state_d = ST_PAUSE;
                    end else begin
                        state_d    = ST_EXEC;
                        bp_armed_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                // One EXEC cycle has passed, so the resume PC is behind us.
                bp_armed_d = 1'b1;
                if (!enable_i) begin
                    state_d = ST_IDLE;
                end else if (halt_det_s) begin
                    state_d = ST_HALTED;
                end else if (bp_match_s) begin
                    state_d  = ST_PAUSE;
                    bp_hit_d = 1'b1;
                end else if (step_mode_i) begin
                    state_d = ST_PAUSE;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_PAUSE: begin
                if (!enable_i) begin
                    state_d = ST_IDLE;
                end else if (step_pulse_s) begin
                    state_d    = ST_STEP;
                    bp_armed_d = 1'b0;
                end else if (start_i && !step_mode_i) begin
                    state_d    = ST_EXEC;
                    bp_armed_d = 1'b0;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            ST_STEP: begin
                if (!enable_i) begin
                    state_d = ST_IDLE;
                end else if (halt_det_s) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            ST_HALTED: begin
                if (!enable_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HALTED;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Saturating counters; they only move while the pipeline advances
    always_comb begin
        cycle_count_d   = cycle_count_q;
        retired_count_d = retired_count_q;
        if (clr_cnt_s) begin
            cycle_count_d   = '0;
            retired_count_d = '0;
        end else if (run_q) begin
            if (cycle_count_q != CNT_MAX) begin
                cycle_count_d = cycle_count_q + CNT_ONE;
            end else begin
                cycle_count_d = cycle_count_q;
            end
            if (wb_valid_i && (retired_count_q != CNT_MAX)) begin
                retired_count_d = retired_count_q + CNT_ONE;
            end else begin
                retired_count_d = retired_count_q;
            end
        end else begin
            cycle_count_d   = cycle_count_q;
            retired_count_d = retired_count_q;
        end
    end

    // State, registered Moore outputs and counter registers
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q         <= ST_IDLE;
            run_q           <= 1'b0;
            halted_q        <= 1'b0;
            bp_hit_q        <= 1'b0;
            step_req_q      <= 1'b0;
            bp_armed_q      <= 1'b0;
            cycle_count_q   <= '0;
            retired_count_q <= '0;
        end else begin
            state_q         <= state_d;
            run_q           <= (state_d == ST_EXEC) || (state_d == ST_STEP);
            halted_q        <= (state_d == ST_HALTED);
            bp_hit_q        <= bp_hit_d;
            step_req_q      <= step_req_i;
            bp_armed_q      <= bp_armed_d;
            cycle_count_q   <= cycle_count_d;
            retired_count_q <= retired_count_d;
        end
    end

    assign run_o           = run_q;
    assign state_o         = state_q;
    assign halted_o        = halted_q;
    assign bp_hit_o        = bp_hit_q;
    assign cycle_count_o   = cycle_count_q;
    assign retired_count_o = retired_count_q;

endmodule

// File: tb/tb_cpu_run_control.sv
// Self-checking bench for cpu_run_control: directed scenarios plus a random run
// compared against a behavioural model; a CNT_WIDTH=4 copy shares the stimulus.
module tb_cpu_run_control;

    logic        clk = 1'b0;
    logic        rst, start, enable, step_mode, step_req, bp_en, wb_valid;
    logic [7:0]  bp_addr, pc;
    logic [15:0] wb_ir;

    logic        run16, halted16, bphit16, run4, halted4, bphit4;
    logic [2:0]  st16, st4;
    logic [15:0] cyc16, ret16;
    logic [3:0]  cyc4, ret4;

    int n_tests = 0;
    int n_fail  = 0;

    // behavioural model state
    int m_st = 0, m_cyc = 0, m_ret = 0;
    bit m_hit = 1'b0, m_arm = 1'b0, m_sq = 1'b0;

    always #5 clk = ~clk;

    cpu_run_control u_dut (
        .clock_i(clk), .reset_i(rst), .start_i(start), .enable_i(enable),
        .step_mode_i(step_mode), .step_req_i(step_req), .bp_en_i(bp_en),
        .bp_addr_i(bp_addr), .pc_i(pc), .wb_ir_i(wb_ir), .wb_valid_i(wb_valid),
        .run_o(run16), .state_o(st16), .halted_o(halted16), .bp_hit_o(bphit16),
        .cycle_count_o(cyc16), .retired_count_o(ret16)
    );

    cpu_run_control #(.CNT_WIDTH(4)) u_dut4 (
        .clock_i(clk), .reset_i(rst), .start_i(start), .enable_i(enable),
        .step_mode_i(step_mode), .step_req_i(step_req), .bp_en_i(bp_en),
        .bp_addr_i(bp_addr), .pc_i(pc), .wb_ir_i(wb_ir), .wb_valid_i(wb_valid),
        .run_o(run4), .state_o(st4), .halted_o(halted4), .bp_hit_o(bphit4),
        .cycle_count_o(cyc4), .retired_count_o(ret4)
    );

    // Model: 0 idle, 1 exec, 2 pause, 3 step, 4 halted
    task automatic model_update();
        bit running, halt, spulse, bpm;
        int nxt;
        bit nhit, narm, clr;
        running = (m_st == 1) || (m_st == 3);
        halt    = wb_valid && (wb_ir[15:11] == 5'd1);
        spulse  = step_req && !m_sq;
        bpm     = bp_en && m_arm && (pc == bp_addr);
        nxt = m_st; nhit = 1'b0; narm = m_arm; clr = 1'b0;
        if (rst) begin
            m_st = 0; m_cyc = 0; m_ret = 0; m_hit = 1'b0; m_sq = 1'b0; m_arm = 1'b0;
            return;
        end
        if (m_st == 0) begin
            if (start && enable) begin
                clr = 1'b1;
                nxt = step_mode ? 2 : 1;
                if (!step_mode) narm = 1'b1;
            end
        end else if (m_st == 1) begin
            narm = 1'b1;
            if (!enable) nxt = 0;
            else if (halt) nxt = 4;
            else if (bpm) begin nxt = 2; nhit = 1'b1; end
            else if (step_mode) nxt = 2;
        end else if (m_st == 2) begin
            if (!enable) nxt = 0;
            else if (spulse) begin nxt = 3; narm = 1'b0; end
            else if (start && !step_mode) begin nxt = 1; narm = 1'b0; end
        end else if (m_st == 3) begin
            if (!enable) nxt = 0;
            else if (halt) nxt = 4;
            else nxt = 2;
        end else begin
            if (!enable) nxt = 0;
        end
        if (clr) begin
            m_cyc = 0; m_ret = 0;
        end else if (running) begin
            m_cyc++;
            if (wb_valid) m_ret++;
        end
        m_st = nxt; m_hit = nhit; m_arm = narm; m_sq = step_req;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic quiet_inputs();
        start = 1'b0; enable = 1'b0; step_mode = 1'b0; step_req = 1'b0;
        bp_en = 1'b0; bp_addr = 8'h00; pc = 8'h00; wb_ir = 16'h0000; wb_valid = 1'b0;
    endtask

    task automatic do_reset();
        quiet_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [15:0] rand_ir(input bit is_halt);
        logic [4:0] op;
        op = is_halt ? 5'd1 : 5'($urandom_range(2, 31));
        return {op, 11'($urandom)};
    endfunction

    task automatic test_reset();
        do_reset();
        tick();
        n_tests++;
        if (st16 !== 3'd0 || run16 !== 1'b0 || halted16 !== 1'b0 || bphit16 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d run=%0d halted=%0d bp_hit=%0d, want 0 0 0 0", st16, run16, halted16, bphit16);
        end
        n_tests++;
        if (cyc16 !== 16'd0 || ret16 !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_counters: cycles=%0d retired=%0d, want 0 0", cyc16, ret16);
        end
        start = 1'b1; enable = 1'b1;
        tick();
        n_tests++;
        if (st16 !== 3'd1 || run16 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_start: state=%0d run=%0d, want 1 1", st16, run16);
        end
    endtask

    task automatic test_halt();
        logic [9:0] mask;
        int rot;
        mask = 10'b1110011010;
        rot = $urandom_range(0, 9);
        do_reset();
        start = 1'b1; enable = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            wb_valid = mask[(i + rot) % 10];
            wb_ir = rand_ir(1'b0);
            tick();
        end
        n_tests++;
        if (st16 !== 3'd1) begin
            n_fail++;
            $display("FAIL halt_exec_run: state=%0d, want 1", st16);
        end
        wb_ir = rand_ir(1'b1); wb_valid = 1'b1;
        tick();
        wb_valid = 1'b0;
        n_tests++;
        if (st16 !== 3'd4 || halted16 !== 1'b1 || run16 !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_state: state=%0d halted=%0d run=%0d, want 4 1 0", st16, halted16, run16);
        end
        n_tests++;
        if (cyc16 !== 16'd11 || ret16 !== 16'd7) begin
            n_fail++;
            $display("FAIL halt_counts: cycles=%0d retired=%0d, want 11 7", cyc16, ret16);
        end
        tick();
        tick();
        n_tests++;
        if (st16 !== 3'd4 || cyc16 !== 16'd11 || ret16 !== 16'd7) begin
            n_fail++;
            $display("FAIL halt_hold: state=%0d cycles=%0d retired=%0d, want 4 11 7", st16, cyc16, ret16);
        end
        enable = 1'b0;
        tick();
        n_tests++;
        if (st16 !== 3'd0 || halted16 !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_disable: state=%0d halted=%0d, want 0 0", st16, halted16);
        end
    endtask

    task automatic test_breakpoint();
        do_reset();
        bp_en = 1'b1; bp_addr = 8'h20; pc = 8'h1C;
        start = 1'b1; enable = 1'b1;
        tick();
        start = 1'b0;
        for (int p = 8'h1D; p <= 8'h20; p++) begin
            pc = 8'(p);
            tick();
            if (p < 8'h20) begin
                n_tests++;
                if (st16 !== 3'd1 || bphit16 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_early pc=%0h: state=%0d bp_hit=%0d, want 1 0", p, st16, bphit16);
                end
            end
        end
        n_tests++;
        if (st16 !== 3'd2 || bphit16 !== 1'b1 || run16 !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_stop: state=%0d bp_hit=%0d run=%0d, want 2 1 0", st16, bphit16, run16);
        end
        tick();
        n_tests++;
        if (st16 !== 3'd2 || bphit16 !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_pulse: state=%0d bp_hit=%0d, want 2 0", st16, bphit16);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_tests++;
        if (st16 !== 3'd1) begin
            n_fail++;
            $display("FAIL bp_resume: state=%0d, want 1", st16);
        end
        tick();
        pc = 8'h21;
        n_tests++;
        if (st16 !== 3'd1 || bphit16 !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_no_rehit: state=%0d bp_hit=%0d, want 1 0", st16, bphit16);
        end
        tick();
        n_tests++;
        if (st16 !== 3'd1) begin
            n_fail++;
            $display("FAIL bp_continue: state=%0d, want 1", st16);
        end
    endtask

    task automatic test_step();
        do_reset();
        step_mode = 1'b1; start = 1'b1; enable = 1'b1;
        tick();
        start = 1'b0;
        n_tests++;
        if (st16 !== 3'd2 || run16 !== 1'b0 || cyc16 !== 16'd0) begin
            n_fail++;
            $display("FAIL step_pause: state=%0d run=%0d cycles=%0d, want 2 0 0", st16, run16, cyc16);
        end
        step_req = 1'b1;
        tick();
        n_tests++;
        if (st16 !== 3'd3 || run16 !== 1'b1) begin
            n_fail++;
            $display("FAIL step_enter: state=%0d run=%0d, want 3 1", st16, run16);
        end
        tick();
        tick();
        n_tests++;
        if (st16 !== 3'd2 || cyc16 !== 16'd1) begin
            n_fail++;
            $display("FAIL step_once: state=%0d cycles=%0d, want 2 1", st16, cyc16);
        end
        step_req = 1'b0;
        tick();
        step_req = 1'b1;
        tick();
        tick();
        n_tests++;
        if (st16 !== 3'd2 || cyc16 !== 16'd2) begin
            n_fail++;
            $display("FAIL step_twice: state=%0d cycles=%0d, want 2 2", st16, cyc16);
        end
        step_req = 1'b0;
        tick();
        step_req = 1'b1; enable = 1'b0;
        tick();
        n_tests++;
        if (st16 !== 3'd0) begin
            n_fail++;
            $display("FAIL step_disable: state=%0d, want 0", st16);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        bp_en = 1'b1; bp_addr = 8'h44; pc = 8'h40;
        start = 1'b1; enable = 1'b1;
        tick();
        pc = 8'h44; wb_ir = rand_ir(1'b1); wb_valid = 1'b1;
        tick();
        wb_valid = 1'b0;
        n_tests++;
        if (st16 !== 3'd4 || bphit16 !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_halt_bp: state=%0d bp_hit=%0d, want 4 0", st16, bphit16);
        end
        do_reset();
        start = 1'b1; enable = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        n_tests++;
        if (st16 !== 3'd0 || run16 !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_disable: state=%0d run=%0d, want 0 0", st16, run16);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        start = 1'b1; enable = 1'b1;
        tick();
        wb_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wb_ir = rand_ir(1'b0);
            tick();
        end
        n_tests++;
        if (cyc4 !== 4'd15 || ret4 !== 4'd15) begin
            n_fail++;
            $display("FAIL sat_4bit: cycles=%0d retired=%0d, want 15 15", cyc4, ret4);
        end
        n_tests++;
        if (cyc16 !== 16'd20 || ret16 !== 16'd20) begin
            n_fail++;
            $display("FAIL sat_16bit: cycles=%0d retired=%0d, want 20 20", cyc16, ret16);
        end
        tick();
        tick();
        n_tests++;
        if (cyc4 !== 4'd15 || st4 !== 3'd1) begin
            n_fail++;
            $display("FAIL sat_hold: cycles=%0d state=%0d, want 15 1", cyc4, st4);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if (st16 !== 3'd0 || cyc16 !== 16'd0 || ret16 !== 16'd0 || cyc4 !== 4'd0 || run16 !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: state=%0d cycles=%0d retired=%0d cycles4=%0d run=%0d, want 0 0 0 0 0",
                     st16, cyc16, ret16, cyc4, run16);
        end
    endtask

    task automatic test_random();
        int sat16, sat4r, sat4c;
        bit exp_run;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 299) == 0);
            enable   = ($urandom_range(0, 24) != 0);
            start    = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 19) == 0) step_mode = ~step_mode;
            step_req = ($urandom_range(0, 3) == 0) ? ~step_req : step_req;
            bp_en    = ($urandom_range(0, 3) != 0);
            bp_addr  = 8'h10;
            pc       = 8'h0C + 8'($urandom_range(0, 7));
            wb_valid = $urandom_range(0, 1);
            wb_ir    = rand_ir($urandom_range(0, 39) == 0);
            tick();
            exp_run = (m_st == 1) || (m_st == 3);
            sat16 = (m_cyc > 65535) ? 65535 : m_cyc;
            sat4c = (m_cyc > 15) ? 15 : m_cyc;
            sat4r = (m_ret > 15) ? 15 : m_ret;
            n_tests++;
            if (int'(st16) != m_st || run16 !== exp_run || halted16 !== (m_st == 4) || bphit16 !== m_hit) begin
                n_fail++;
                $display("FAIL rand_ctrl cyc %0d: state=%0d run=%0d halted=%0d bp_hit=%0d, want %0d %0d %0d %0d",
                         i, st16, run16, halted16, bphit16, m_st, exp_run, (m_st == 4), m_hit);
            end
            n_tests++;
            if (int'(cyc16) != sat16 || int'(ret16) != m_ret || int'(cyc4) != sat4c || int'(ret4) != sat4r) begin
                n_fail++;
                $display("FAIL rand_counts cyc %0d: c16=%0d r16=%0d c4=%0d r4=%0d, want %0d %0d %0d %0d",
                         i, cyc16, ret16, cyc4, ret4, sat16, m_ret, sat4c, sat4r);
            end
            n_tests++;
            if (int'(st4) != m_st || run4 !== exp_run || bphit4 !== m_hit || halted4 !== (m_st == 4)) begin
                n_fail++;
                $display("FAIL rand_ctrl4 cyc %0d: state=%0d run=%0d bp_hit=%0d, want %0d %0d %0d",
                         i, st4, run4, bphit4, m_st, exp_run, m_hit);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        quiet_inputs();
        test_reset();
        test_halt();
        test_breakpoint();
        test_step();
        test_simultaneous();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
